// File: rtl/run_detect_ctrl_if.sv
// Config, control and serial-stream bundle for the run detector sequencer.
// The host (master) drives requests and bits; the detector (slave) returns status.
interface run_detect_ctrl_if #(
  parameter int MAXLEN = 8,
  parameter int CNT_W  = 8
);
  localparam int LEN_W = $clog2(MAXLEN + 1);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [LEN_W-1:0] cfg_len;
  logic [1:0]       cfg_pol;
  logic [CNT_W-1:0] cfg_limit;
  logic             start;
  logic             abort;
  logic             done_ack;
  logic             x_valid;
  logic             x;
  logic             y;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output cfg_valid, cfg_len, cfg_pol, cfg_limit,
    output start, abort, done_ack, x_valid, x,
    input  cfg_ready, y, busy, done, match_cnt
  );

  modport slave (
    input  cfg_valid, cfg_len, cfg_pol, cfg_limit,
    input  start, abort, done_ack, x_valid, x,
    output cfg_ready, y, busy, done, match_cnt
  );
endinterface

// File: rtl/run_detect_ctrl.sv
// Programmable sequencer around a Mealy overlapping run detector: IDLE/RUN/DONE
// control, clamped run-length config, polarity select and a saturating match count.
module run_detect_ctrl #(
  parameter int MAXLEN = 8,
  parameter int CNT_W  = 8
) (
  input logic              clk,
  input logic              rst,
  run_detect_ctrl_if.slave bus
);
  localparam int LEN_W = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Clamp the programmed length into [2, MAXLEN].
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l < LEN_W'(2)) begin
      return LEN_W'(2);
    end else if (l > LEN_W'(MAXLEN)) begin
      return LEN_W'(MAXLEN);
    end else begin
      return l;
    end
  endfunction

  // A polarity of "detect nothing" is treated as "detect both".
  function automatic logic [1:0] norm_pol(input logic [1:0] p);
    if (p == 2'b00) begin
      return 2'b11;
    end else begin
      return p;
    end
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [LEN_W-1:0] len_r;
  logic [1:0]       pol_r;
  logic [CNT_W-1:0] limit_r;
  logic [LEN_W-1:0] run_cnt_r;
  logic             last_bit_r;
  logic [CNT_W-1:0] match_cnt_r;
  logic             cfg_ready_r;
  logic             busy_r;
  logic             done_r;

  logic             same_s;
  logic             pol_ok_s;
  logic             y_s;
  logic [LEN_W-1:0] run_next_s;
  logic [CNT_W-1:0] match_inc_s;
  logic             limit_hit_s;
  logic             start_fire_s;
  logic             bit_fire_s;

  // Run tracking, match flag and counter arithmetic.
  always_comb begin
    same_s       = 1'b0;
    pol_ok_s     = 1'b0;
    y_s          = 1'b0;
    run_next_s   = LEN_W'(1);
    match_inc_s  = match_cnt_r;
    limit_hit_s  = 1'b0;
    start_fire_s = 1'b0;
    bit_fire_s   = 1'b0;

    same_s   = (run_cnt_r != LEN_W'(0)) && (bus.x == last_bit_r);
    pol_ok_s = bus.x ? pol_r[0] : pol_r[1];

    if (same_s) begin
      if (run_cnt_r >= len_r) begin
        run_next_s = len_r;
      end else begin
        run_next_s = run_cnt_r + LEN_W'(1);
      end
    end else begin
      run_next_s = LEN_W'(1);
    end

    if (&match_cnt_r) begin
      match_inc_s = match_cnt_r;
    end else begin
      match_inc_s = match_cnt_r + CNT_W'(1);
    end

    // Widened compare so a saturated counter can never alias the limit.
    limit_hit_s = (limit_r != CNT_W'(0)) &&
                  (({1'b0, match_cnt_r} + (CNT_W + 1)'(1)) == {1'b0, limit_r});

    bit_fire_s   = (state_r == ST_RUN) && bus.x_valid && !bus.abort;
    start_fire_s = (state_r == ST_IDLE) && bus.start && !bus.abort;
    y_s          = bit_fire_s && same_s &&
                   (run_cnt_r >= (len_r - LEN_W'(1))) && pol_ok_s;
  end

  // Next-state selection; abort dominates every other request.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else if (bus.start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else if (y_s && limit_hit_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.abort || bus.done_ack) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cfg_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cfg_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s == ST_RUN);
      done_r      <= (state_s == ST_DONE);
    end
  end

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r   <= LEN_W'(3);
      pol_r   <= 2'b11;
      limit_r <= CNT_W'(0);
    end else if ((state_r == ST_IDLE) && bus.cfg_valid) begin
      len_r   <= clamp_len(bus.cfg_len);
      pol_r   <= norm_pol(bus.cfg_pol);
      limit_r <= bus.cfg_limit;
    end else begin
      len_r   <= len_r;
      pol_r   <= pol_r;
      limit_r <= limit_r;
    end
  end

  // Run history and match counter; held on invalid bits, in DONE and on abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_r   <= LEN_W'(0);
      last_bit_r  <= 1'b0;
      match_cnt_r <= CNT_W'(0);
    end else if (start_fire_s) begin
      run_cnt_r   <= LEN_W'(0);
      last_bit_r  <= 1'b0;
      match_cnt_r <= CNT_W'(0);
    end else if (bit_fire_s) begin
      run_cnt_r   <= run_next_s;
      last_bit_r  <= bus.x;
      match_cnt_r <= y_s ? match_inc_s : match_cnt_r;
    end else begin
      run_cnt_r   <= run_cnt_r;
      last_bit_r  <= last_bit_r;
      match_cnt_r <= match_cnt_r;
    end
  end

  assign bus.y         = y_s;
  assign bus.cfg_ready = cfg_ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.match_cnt = match_cnt_r;

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Bench for run_detect_ctrl: directed vector table, corner sequences and a
// randomized run checked against a bit-history reference model.
module tb_run_detect_ctrl;
  localparam int MAXLEN = 8;
  localparam int CNT_W  = 8;
  localparam int LEN_W  = $clog2(MAXLEN + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  run_detect_ctrl_if #(.MAXLEN(MAXLEN), .CNT_W(CNT_W)) bus();
  run_detect_ctrl #(.MAXLEN(MAXLEN), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0=idle 1=run 2=done, plus the valid-bit history of the run.
  int m_mode, m_len, m_pol, m_limit, m_cnt;
  bit hist[$];

  typedef struct {
    bit st;
    bit xv;
    bit xb;
    bit ey;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_len = 3; m_pol = 3; m_limit = 0; m_cnt = 0;
    hist.delete();
  endtask

  // A match is "the trailing run of identical valid bits, including this one, reaches len".
  function automatic int model_y(bit xv, bit xb, bit ab);
    int run;
    if (m_mode != 1 || !xv || ab) return 0;
    if (!(xb ? m_pol[0] : m_pol[1])) return 0;
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == xb) run++;
      else break;
    end
    return (run >= m_len - 1) ? 1 : 0;
  endfunction

  task automatic model_step(input bit cv, input int clen, input int cpol, input int climit,
                            input bit st, input bit ab, input bit ack, input bit xv,
                            input bit xb, input int yv);
    case (m_mode)
      0: begin
        if (cv) begin
          m_len   = (clen < 2) ? 2 : ((clen > MAXLEN) ? MAXLEN : clen);
          m_pol   = (cpol == 0) ? 3 : cpol;
          m_limit = climit;
        end
        if (st && !ab) begin
          m_mode = 1; m_cnt = 0; hist.delete();
        end
      end
      1: begin
        if (ab) m_mode = 0;
        else if (xv) begin
          if (yv != 0) begin
            if (m_limit != 0 && m_cnt + 1 == m_limit) m_mode = 2;
            if (m_cnt != (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
          end
          hist.push_back(xb);
          if (hist.size() > MAXLEN) hist.pop_front();
        end
      end
      default: begin
        if (ab || ack) m_mode = 0;
      end
    endcase
  endtask

  // One clock: apply inputs, check everything against the model at the falling edge.
  task automatic drive(input bit r, input bit cv, input int clen, input int cpol,
                       input int climit, input bit st, input bit ab, input bit ack,
                       input bit xv, input bit xb, output bit ys);
    int ey;
    rst           = r;
    bus.cfg_valid = cv;
    bus.cfg_len   = clen[LEN_W-1:0];
    bus.cfg_pol   = cpol[1:0];
    bus.cfg_limit = climit[CNT_W-1:0];
    bus.start     = st;
    bus.abort     = ab;
    bus.done_ack  = ack;
    bus.x_valid   = xv;
    bus.x         = xb;
    @(negedge clk);
    ey = model_y(xv, xb, ab);
    ys = bus.y;
    if (!r) check("y", bus.y, ey);
    check("busy", bus.busy, m_mode == 1);
    check("done", bus.done, m_mode == 2);
    check("cfg_ready", bus.cfg_ready, m_mode == 0);
    check("match_cnt", bus.match_cnt, m_cnt);
    if (r) model_reset();
    else model_step(cv, clen, cpol, climit, st, ab, ack, xv, xb, ey);
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input bit xv, input bit xb, output bit ys);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, xv, xb, ys);
  endtask

  task automatic start_run();
    bit d;
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic cfg(input int l, input int p, input int lim);
    bit d;
    drive(1'b0, 1'b1, l, p, lim, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic abort_cyc(input bit xv, input bit xb, output bit ys);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, xv, xb, ys);
  endtask

  initial begin
    bit ys;
    bit yv[9];
    bit prev;

    bus.cfg_valid = 1'b0; bus.cfg_len = '0; bus.cfg_pol = 2'b00; bus.cfg_limit = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.done_ack = 1'b0;
    bus.x_valid = 1'b0; bus.x = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Reset state
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_match_cnt", bus.match_cnt, 0);
    check("rst_y", bus.y, 0);

    // Default "111 or 000" detector, table-driven
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 0, 0, 0, tbl[i].st, 1'b0, 1'b0, tbl[i].xv, tbl[i].xb, ys);
      check($sformatf("tbl_y[%0d]", i), ys, tbl[i].ey);
    end
    check("tbl_match_cnt", bus.match_cnt, 3);
    abort_cyc(1'b0, 1'b0, ys);

    // len=4, ones only, limit=2
    cfg(4, 1, 2);
    start_run();
    for (int i = 0; i < 9; i++) begin
      bit_in(1'b1, (i >= 4), yv[i]);
      check($sformatf("lim_y[%0d]", i), yv[i], (i == 7 || i == 8));
    end
    check("lim_done", bus.done, 1);
    check("lim_match_cnt", bus.match_cnt, 2);
    bit_in(1'b1, 1'b1, ys);
    check("done_y_ignored", ys, 0);
    check("done_cnt_held", bus.match_cnt, 2);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ys);
    check("ack_idle", bus.cfg_ready, 1);
    check("ack_cnt_kept", bus.match_cnt, 2);

    // cfg and start together (len=3, both, unlimited); gaps do not break the run
    drive(1'b0, 1'b1, 3, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ys);
    bit_in(1'b1, 1'b1, ys); check("gap_y0", ys, 0);
    bit_in(1'b0, 1'b0, ys); check("gap_y1", ys, 0);
    bit_in(1'b1, 1'b1, ys); check("gap_y2", ys, 0);
    bit_in(1'b0, 1'b1, ys); check("gap_y3", ys, 0);
    bit_in(1'b0, 1'b0, ys); check("gap_y4", ys, 0);
    bit_in(1'b1, 1'b1, ys); check("gap_y5", ys, 1);
    check("gap_cnt", bus.match_cnt, 1);

    // Abort on a would-be matching bit
    abort_cyc(1'b1, 1'b1, ys);
    check("abort_y", ys, 0);
    check("abort_idle", bus.cfg_ready, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_cnt", bus.match_cnt, 1);

    // Out-of-range config clamps to len=2, both polarities
    cfg(0, 0, 0);
    start_run();
    bit_in(1'b1, 1'b0, ys); check("clamp_y0", ys, 0);
    bit_in(1'b1, 1'b0, ys); check("clamp_y1", ys, 1);
    bit_in(1'b1, 1'b1, ys); check("clamp_y2", ys, 0);
    bit_in(1'b1, 1'b1, ys); check("clamp_y3", ys, 1);
    // Config while busy is refused
    drive(1'b0, 1'b1, 5, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ys);
    check("busy_cfg_ready", bus.cfg_ready, 0);
    bit_in(1'b1, 1'b0, ys); check("busy_cfg_y0", ys, 0);
    bit_in(1'b1, 1'b0, ys); check("busy_cfg_y1", ys, 1);
    check("busy_cfg_still_run", bus.busy, 1);
    abort_cyc(1'b0, 1'b0, ys);

    // rst mid-run with run_cnt=2
    start_run();
    bit_in(1'b1, 1'b1, ys);
    bit_in(1'b1, 1'b1, ys);
    drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ys);
    check("mrst_cfg_ready", bus.cfg_ready, 1);
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_cnt", bus.match_cnt, 0);
    start_run();
    bit_in(1'b1, 1'b1, ys);
    check("mrst_hist_cleared", ys, 0);

    // Randomized traffic against the model
    prev = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bit r, cv, st, ab, ack, xv, xb;
      r   = ($urandom_range(0, 299) == 0);
      cv  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 3) == 0);
      ab  = ($urandom_range(0, 59) == 0);
      ack = ($urandom_range(0, 7) == 0);
      xv  = ($urandom_range(0, 3) != 0);
      xb  = ($urandom_range(0, 3) == 0) ? ~prev : prev;
      prev = xb;
      drive(r, cv, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 6),
            st, ab, ack, xv, xb, ys);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
